// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: widths, RV32I
// load/store funct3 encodings, FSM state encoding and the byte-lane word type.
package lsu_pkg;

  localparam int XLEN      = 32;
  localparam int BYTE_SIZE = 8;
  localparam int MEM_STEPS = XLEN / BYTE_SIZE;

  // RV32I load/store width encodings (bit 2 = unsigned for loads)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } lsu_state_t;

  // One memory word, lane i holds byte i (little-endian)
  typedef logic [MEM_STEPS-1:0][BYTE_SIZE-1:0] mem_word_t;

endpackage

// File: rtl/lsu_align.sv
// Purely combinational byte-lane logic for the load/store unit:
// load extraction with sign/zero extension, read-modify-write lane merge
// for sub-word stores, and the misalignment / illegal-funct3 check.
module lsu_align
  import lsu_pkg::*;
(
  input  mem_word_t        i_word,
  input  logic [XLEN-1:0]  i_wdata,
  input  logic [1:0]       i_offset,
  input  logic [2:0]       i_funct3,
  input  logic             i_store,
  output logic [XLEN-1:0]  o_load_data,
  output mem_word_t        o_store_word,
  output logic             o_err
);

  logic [BYTE_SIZE-1:0]   w_byte;
  logic [2*BYTE_SIZE-1:0] w_half;
  logic [1:0]             w_half_lo;
  logic [1:0]             w_half_hi;
  logic                   w_illegal;
  logic                   w_misaligned;

  // Halfwords are only legal at offsets 0 and 2, so the lane pair is
  // selected by offset[1]; a misaligned request is flagged as an error.
  assign w_half_lo = {i_offset[1], 1'b0};
  assign w_half_hi = {i_offset[1], 1'b1};
  assign w_byte    = i_word[i_offset];
  assign w_half    = {i_word[w_half_hi], i_word[w_half_lo]};

  // Load extraction and extension
  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    o_load_data = '0;
    case (i_funct3)
      F3_B:    o_load_data = {{(XLEN-BYTE_SIZE){w_byte[BYTE_SIZE-1]}}, w_byte};
      F3_BU:   o_load_data = {{(XLEN-BYTE_SIZE){1'b0}}, w_byte};
      F3_H:    o_load_data = {{(XLEN-2*BYTE_SIZE){w_half[2*BYTE_SIZE-1]}}, w_half};
      F3_HU:   o_load_data = {{(XLEN-2*BYTE_SIZE){1'b0}}, w_half};
      F3_W:    o_load_data = i_word;
      default: o_load_data = '0;
    endcase
  end

  // Store merge: replace the addressed lanes of the old word
  always_comb begin
    o_store_word = i_word;
    case (i_funct3)
      F3_B: o_store_word[i_offset] = i_wdata[BYTE_SIZE-1:0];
      F3_H: begin
        o_store_word[w_half_lo] = i_wdata[BYTE_SIZE-1:0];
        o_store_word[w_half_hi] = i_wdata[2*BYTE_SIZE-1:BYTE_SIZE];
      end
      F3_W:    o_store_word = i_wdata;
      default: o_store_word = i_word;
    endcase
  end

  // Illegal encodings and alignment check
  always_comb begin
    if (i_store) begin
      w_illegal = i_funct3[2] || (i_funct3[1:0] == 2'b11);
    end else begin
      w_illegal = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) ||
                  (i_funct3 == 3'b111);
    end
    w_misaligned = 1'b0;
    if (i_funct3[1:0] == 2'b01) begin
      w_misaligned = i_offset[0];
    end else if (i_funct3[1:0] == 2'b10) begin
      w_misaligned = (i_offset != 2'b00);
    end
    o_err = w_illegal || w_misaligned;
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one load/store at a time, checks alignment,
// drives registered memory enables/addresses/data (read-modify-write for
// SB/SH since memory has no byte enables) and returns extended load data.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  output logic             mem_read_enable,
  output logic             mem_write_enable,
  output logic [XLEN-1:0]  mem_read_addr,
  output logic [XLEN-1:0]  mem_write_addr,
  output mem_word_t        mem_write_data,
  input  mem_word_t        mem_read_data,
  output logic             resp_valid,
  output logic [XLEN-1:0]  resp_data,
  output logic             resp_err
);

  lsu_state_t       r_state;
  lsu_state_t       w_state_next;

  // Latched request
  logic             r_store;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_addr;
  logic [XLEN-1:0]  r_wdata;

  // Word buffer holding the last word read from memory
  mem_word_t        r_buf;

  // Registered outputs
  logic             r_mem_read_enable;
  logic             r_mem_write_enable;
  logic [XLEN-1:0]  r_mem_read_addr;
  logic [XLEN-1:0]  r_mem_write_addr;
  mem_word_t        r_mem_write_data;
  logic             r_resp_valid;
  logic [XLEN-1:0]  r_resp_data;
  logic             r_resp_err;

  // Current request view: live inputs while idle, latched copy otherwise
  logic             w_idle;
  logic             w_accept;
  logic             w_cur_store;
  logic [2:0]       w_cur_funct3;
  logic [XLEN-1:0]  w_cur_addr;
  logic [XLEN-1:0]  w_cur_wdata;
  logic [XLEN-1:0]  w_word_idx;
  mem_word_t        w_align_word;
  logic [XLEN-1:0]  w_load_data;
  mem_word_t        w_store_word;
  logic             w_err;

  assign w_idle       = (r_state == IDLE);
  assign w_accept     = req_valid && w_idle;
  assign w_cur_store  = w_idle ? req_store  : r_store;
  assign w_cur_funct3 = w_idle ? req_funct3 : r_funct3;
  assign w_cur_addr   = w_idle ? req_addr   : r_addr;
  assign w_cur_wdata  = w_idle ? req_wdata  : r_wdata;

  // Memory is indexed by word and is 1-based; wrap is plain XLEN truncation
  assign w_word_idx = {2'b00, w_cur_addr[XLEN-1:2]} + XLEN'(1);

  // Fresh memory data during READ, otherwise the held buffer
  assign w_align_word = (r_state == READ) ? mem_read_data : r_buf;

  lsu_align u_align (
    .i_word       (w_align_word),
    .i_wdata      (w_cur_wdata),
    .i_offset     (w_cur_addr[1:0]),
    .i_funct3     (w_cur_funct3),
    .i_store      (w_cur_store),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word),
    .o_err        (w_err)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_err) begin
            w_state_next = ERR;
          end else if (req_store && (req_funct3 == F3_W)) begin
            w_state_next = WRITE;
          end else begin
            w_state_next = READ;
          end
        end
      end
      READ:    w_state_next = r_store ? WRITE : RESP;
      WRITE:   w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      ERR:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Request latch and word buffer
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the buffer is a handful of flops, not a RAM, so it is reset
    // along with the rest of the state.
    if (!rst_n) begin
      r_store  <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_buf    <= '0;
    end else begin
      if (w_accept) begin
        r_store  <= req_store;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (r_state == READ) begin
        r_buf <= mem_read_data;
      end
    end
  end

  // Registered memory and response outputs, decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_read_enable  <= 1'b0;
      r_mem_write_enable <= 1'b0;
      r_mem_read_addr    <= '0;
      r_mem_write_addr   <= '0;
      r_mem_write_data   <= '0;
      r_resp_valid       <= 1'b0;
      r_resp_data        <= '0;
      r_resp_err         <= 1'b0;
    end else begin
      r_mem_read_enable  <= (w_state_next == READ);
      r_mem_write_enable <= (w_state_next == WRITE);
      if (w_state_next == READ) begin
        r_mem_read_addr <= w_word_idx;
      end
      if (w_state_next == WRITE) begin
        r_mem_write_addr <= w_word_idx;
        r_mem_write_data <= w_store_word;
      end else begin
        r_mem_write_data <= '0;
      end
      r_resp_valid <= (w_state_next == RESP) || (w_state_next == ERR);
      r_resp_err   <= (w_state_next == ERR);
      if ((r_state == READ) && !r_store) begin
        r_resp_data <= w_load_data;
      end else begin
        r_resp_data <= '0;
      end
    end
  end

  assign req_ready        = w_idle;
  assign mem_read_enable  = r_mem_read_enable;
  assign mem_write_enable = r_mem_write_enable;
  assign mem_read_addr    = r_mem_read_addr;
  assign mem_write_addr   = r_mem_write_addr;
  assign mem_write_data   = r_mem_write_data;
  assign resp_valid       = r_resp_valid;
  assign resp_data        = r_resp_data;
  assign resp_err         = r_resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-indexed memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_store;
  logic [2:0]       req_funct3;
  logic [XLEN-1:0]  req_addr;
  logic [XLEN-1:0]  req_wdata;
  logic             mem_read_enable;
  logic             mem_write_enable;
  logic [XLEN-1:0]  mem_read_addr;
  logic [XLEN-1:0]  mem_write_addr;
  mem_word_t        mem_write_data;
  mem_word_t        mem_read_data;
  logic             resp_valid;
  logic [XLEN-1:0]  resp_data;
  logic             resp_err;

  load_store_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_store        (req_store),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_read_addr    (mem_read_addr),
    .mem_write_addr   (mem_write_addr),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .resp_err         (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model (16 words, indexed by low word-index bits) and monitors
  logic [31:0] mem [16];
  logic        bd_we;
  logic [3:0]  bd_idx;
  logic [31:0] bd_data;
  int          wr_count, rd_count, both_count, acc_count, resp_count;
  logic        acc_flag;
  logic [31:0] last_waddr, last_wdata, last_raddr;

  assign mem_read_data = mem[mem_read_addr[3:0]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_write_enable) mem[mem_write_addr[3:0]] <= mem_write_data;
    if (mem_write_enable) begin
      wr_count   <= wr_count + 1;
      last_waddr <= mem_write_addr;
      last_wdata <= mem_write_data;
    end
    if (mem_read_enable) begin
      rd_count   <= rd_count + 1;
      last_raddr <= mem_read_addr;
    end
    if (mem_read_enable && mem_write_enable) both_count <= both_count + 1;
    if (resp_valid) resp_count <= resp_count + 1;
    acc_flag <= req_valid && req_ready;
    if (req_valid && req_ready) acc_count <= acc_count + 1;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic backdoor(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Issue one request and measure latency (accept edge to resp_valid)
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] data,
                        output logic err, output logic pulse_after,
                        output int rd_d, output int wr_d);
    int rd0, wr0;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    rd0 = rd_count; wr0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    data = resp_data;
    err  = resp_err;
    rd_d = rd_count - rd0;
    wr_d = wr_count - wr0;
    @(posedge clk); #1;
    pulse_after = resp_valid;
  endtask

  int          lat, rd_d, wr_d, a0, r0, w0;
  logic [31:0] data;
  logic        err, pa;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    wr_count = 0; rd_count = 0; both_count = 0; acc_count = 0; resp_count = 0;
    last_waddr = '0; last_wdata = '0; last_raddr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rd_en", 32'(mem_read_enable), 32'd0);
    chk("rst_wr_en", 32'(mem_write_enable), 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    backdoor(4'd5, 32'h80FF_7F01);
    backdoor(4'd3, 32'h1122_3344);
    backdoor(4'd0, 32'h1234_5678);

    // Loads from word 5
    run_op(1'b0, F3_B, 32'h11, '0, lat, data, err, pa, rd_d, wr_d);
    chk("lb11_lat", lat, 2); chk("lb11_data", data, 32'h0000_007F);
    chk("lb11_err", 32'(err), 0); chk("lb11_pulse", 32'(pa), 0);
    chk("lb11_rd", rd_d, 1); chk("lb11_raddr", last_raddr, 32'd5);
    run_op(1'b0, F3_B, 32'h12, '0, lat, data, err, pa, rd_d, wr_d);
    chk("lb12_data", data, 32'hFFFF_FFFF);
    run_op(1'b0, F3_BU, 32'h12, '0, lat, data, err, pa, rd_d, wr_d);
    chk("lbu12_data", data, 32'h0000_00FF);
    run_op(1'b0, F3_H, 32'h12, '0, lat, data, err, pa, rd_d, wr_d);
    chk("lh12_data", data, 32'hFFFF_80FF); chk("lh12_lat", lat, 2);
    run_op(1'b0, F3_HU, 32'h12, '0, lat, data, err, pa, rd_d, wr_d);
    chk("lhu12_data", data, 32'h0000_80FF);
    run_op(1'b0, F3_W, 32'h10, '0, lat, data, err, pa, rd_d, wr_d);
    chk("lw10_data", data, 32'h80FF_7F01);

    // Full-word store
    run_op(1'b1, F3_W, 32'h20, 32'hDEAD_BEEF, lat, data, err, pa, rd_d, wr_d);
    chk("sw_lat", lat, 2); chk("sw_wr", wr_d, 1); chk("sw_rd", rd_d, 0);
    chk("sw_waddr", last_waddr, 32'd9); chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
    chk("sw_mem", mem[9], 32'hDEAD_BEEF); chk("sw_resp_data", data, 0);
    chk("sw_wdata_idle", mem_write_data, 0);

    // Read-modify-write stores
    run_op(1'b1, F3_B, 32'h09, 32'h0000_00AB, lat, data, err, pa, rd_d, wr_d);
    chk("sb_lat", lat, 3); chk("sb_rd", rd_d, 1); chk("sb_wr", wr_d, 1);
    chk("sb_mem", mem[3], 32'h1122_AB44); chk("sb_waddr", last_waddr, 32'd3);
    backdoor(4'd3, 32'h1122_3344);
    run_op(1'b1, F3_H, 32'h0A, 32'h0000_CDEF, lat, data, err, pa, rd_d, wr_d);
    chk("sh_lat", lat, 3); chk("sh_mem", mem[3], 32'hCDEF_3344);

    // Errors
    run_op(1'b0, F3_W, 32'h02, '0, lat, data, err, pa, rd_d, wr_d);
    chk("lw_mis_lat", lat, 1); chk("lw_mis_err", 32'(err), 1);
    chk("lw_mis_data", data, 0); chk("lw_mis_en", rd_d + wr_d, 0);
    chk("lw_mis_pulse", 32'(pa), 0);
    run_op(1'b1, F3_H, 32'h03, 32'hFFFF_FFFF, lat, data, err, pa, rd_d, wr_d);
    chk("sh_mis_lat", lat, 1); chk("sh_mis_err", 32'(err), 1);
    chk("sh_mis_en", rd_d + wr_d, 0);
    run_op(1'b1, 3'b100, 32'h04, 32'h0, lat, data, err, pa, rd_d, wr_d);
    chk("st_ill_err", 32'(err), 1); chk("st_ill_en", rd_d + wr_d, 0);
    run_op(1'b0, 3'b011, 32'h04, 32'h0, lat, data, err, pa, rd_d, wr_d);
    chk("ld_ill_err", 32'(err), 1);

    // Address wrap
    run_op(1'b0, F3_W, 32'hFFFF_FFFC, '0, lat, data, err, pa, rd_d, wr_d);
    chk("wrap_raddr", last_raddr, 32'h4000_0000); chk("wrap_data", data, 32'h1234_5678);

    // Reset in READ of an SB
    backdoor(4'd3, 32'h1122_3344);
    w0 = wr_count;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_B; req_addr = 32'h09; req_wdata = 32'hAB;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rr_in_read", 32'(mem_read_enable), 1);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("rr_ready", 32'(req_ready), 1);
    chk("rr_rd_en", 32'(mem_read_enable), 0);
    chk("rr_wr_en", 32'(mem_write_enable), 0);
    chk("rr_raddr", mem_read_addr, 0);
    chk("rr_waddr", mem_write_addr, 0);
    chk("rr_wdata", mem_write_data, 0);
    chk("rr_resp", 32'(resp_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rr_no_write", wr_count - w0, 0);
    chk("rr_mem", mem[3], 32'h1122_3344);

    // Held req_valid, alternating LW/SW to word 7
    backdoor(4'd7, 32'h0);
    a0 = acc_count; r0 = resp_count;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = F3_W;
    req_addr = 32'h18; req_wdata = 32'h5555_AAAA;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (acc_flag) req_store = ~req_store;
    end
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_accepts", acc_count - a0, 5);
    chk("b2b_resps", resp_count - r0, acc_count - a0);
    chk("b2b_both_en", both_count, 0);
    chk("b2b_mem", mem[7], 32'h5555_AAAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
